// File: rtl/feat_extreme_alu_pkg.sv
// Shared definitions for the per-lane feature extreme/sum ALU.
// Holds the lane op encodings and default geometry.
package feat_extreme_alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 4;

  localparam logic [1:0] FUNC_MIN  = 2'b00;
  localparam logic [1:0] FUNC_MAX  = 2'b01;
  localparam logic [1:0] FUNC_SUM  = 2'b10;
  localparam logic [1:0] FUNC_PASS = 2'b11;

endpackage

// File: rtl/feat_extreme_lane.sv
// One lane of combinational min/max/saturating-sum/pass logic.
// Unsigned compare; ties and hist value 0 are ordinary values.
module feat_extreme_lane
  import feat_extreme_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        func,
  input  logic [DATA_W-1:0] hist_data,
  input  logic              hist_v,
  input  logic [DATA_W-1:0] cur_data,
  input  logic              cur_v,
  output logic [DATA_W-1:0] res_data,
  output logic              res_v,
  output logic              res_sat
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, hist_data} + {1'b0, cur_data};
    res_data = '0;
    res_v    = 1'b0;
    res_sat  = 1'b0;
    if (cur_v) begin
      res_v    = 1'b1;
      res_data = cur_data;
      if (hist_v) begin
        unique case (1'b1)
          (func == FUNC_MIN):
            res_data = (cur_data < hist_data) ? cur_data : hist_data;
          (func == FUNC_MAX):
            res_data = (cur_data > hist_data) ? cur_data : hist_data;
          (func == FUNC_SUM): begin
            // carry out clamps to all-ones
            res_sat  = sum[DATA_W];
            res_data = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
          end
          default:
            res_data = cur_data;
        endcase
      end
    end
  end

endmodule

// File: rtl/feat_extreme_alu.sv
// Multi-lane feature ALU: lanes compute at input, S1 holds results,
// S2 is the output register; valid/ready with stall and flush.
module feat_extreme_alu
  import feat_extreme_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*NUM_CH-1:0]      func,
  input  logic [NUM_CH*DATA_W-1:0] hist_data,
  input  logic [NUM_CH-1:0]        hist_v,
  input  logic [NUM_CH*DATA_W-1:0] cur_data,
  input  logic [NUM_CH-1:0]        cur_v,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_v,
  output logic [NUM_CH-1:0]        out_sat
);

  logic [NUM_CH*DATA_W-1:0] res_data;
  logic [NUM_CH-1:0]        res_v;
  logic [NUM_CH-1:0]        res_sat;

  logic                     s1_valid;
  logic [NUM_CH*DATA_W-1:0] s1_data;
  logic [NUM_CH-1:0]        s1_v;
  logic [NUM_CH-1:0]        s1_sat;

  logic s1_adv;
  logic in_fire;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    feat_extreme_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .func     (func[2*i +: 2]),
      .hist_data(hist_data[i*DATA_W +: DATA_W]),
      .hist_v   (hist_v[i]),
      .cur_data (cur_data[i*DATA_W +: DATA_W]),
      .cur_v    (cur_v[i]),
      .res_data (res_data[i*DATA_W +: DATA_W]),
      .res_v    (res_v[i]),
      .res_sat  (res_sat[i])
    );
  end

  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~clear & (~s1_valid | s1_adv);
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_v      <= '0;
      s1_sat    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_v     <= '0;
      out_sat   <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_data;
          out_v    <= s1_v;
          out_sat  <= s1_sat;
        end
      end
      // operands are captured only on an accepted beat
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_data  <= res_data;
        s1_v     <= res_v;
        s1_sat   <= res_sat;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_feat_extreme_alu.sv
// Directed self-checking bench for feat_extreme_alu.
// Four 8-bit lanes, hand-computed expected results.
module tb_feat_extreme_alu;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] func;
  logic [N*W-1:0] hist_data;
  logic [N-1:0]   hist_v;
  logic [N*W-1:0] cur_data;
  logic [N-1:0]   cur_v;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_v;
  logic [N-1:0]   out_sat;

  int checks;
  int errors;

  feat_extreme_alu #(
    .DATA_W(W),
    .NUM_CH(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .func     (func),
    .hist_data(hist_data),
    .hist_v   (hist_v),
    .cur_data (cur_data),
    .cur_v    (cur_v),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_v    (out_v),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #10;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 ||
        out_v !== '0 || out_sat !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h ov=%b s=%b want all 0",
               out_valid, out_data, out_v, out_sat);
    end
    #6;
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_min_max;
    func      = {2'b11, 2'b10, 2'b01, 2'b00};
    hist_v    = 4'hF;
    cur_v     = 4'hF;
    hist_data = {8'h55, 8'h80, 8'h10, 8'h05};
    cur_data  = {8'h11, 8'h7F, 8'h20, 8'h03};
    run_beat();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11FF2003 ||
        out_v !== 4'hF || out_sat !== 4'h0) begin
      errors++;
      $display("FAIL mix_ops got v=%b d=%h ov=%b s=%b want 1 11ff2003 f 0",
               out_valid, out_data, out_v, out_sat);
    end
    hist_data = {8'hFF, 8'h00, 8'h40, 8'h00};
    cur_data  = {8'h00, 8'h00, 8'h40, 8'h03};
    run_beat();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00004000 ||
        out_v !== 4'hF || out_sat !== 4'h0) begin
      errors++;
      $display("FAIL min_zero_hist got v=%b d=%h ov=%b s=%b want 1 00004000 f 0",
               out_valid, out_data, out_v, out_sat);
    end
    step();
  endtask

  task automatic test_sum;
    func      = 8'hAA;
    hist_v    = 4'hF;
    cur_v     = 4'hF;
    hist_data = {8'h7F, 8'h80, 8'hF0, 8'h01};
    cur_data  = {8'h80, 8'h80, 8'h20, 8'h02};
    run_beat();
    checks++;
    if (out_data !== 32'hFFFFFF03 || out_sat !== 4'b0110 ||
        out_v !== 4'hF) begin
      errors++;
      $display("FAIL sum_sat got d=%h s=%b ov=%b want ffffff03 0110 f",
               out_data, out_sat, out_v);
    end
    hist_data = {8'hFE, 8'h00, 8'h10, 8'hFF};
    cur_data  = {8'h01, 8'h00, 8'h20, 8'h01};
    run_beat();
    checks++;
    if (out_data !== 32'hFF0030FF || out_sat !== 4'b0001 ||
        out_v !== 4'hF) begin
      errors++;
      $display("FAIL sum_nosat got d=%h s=%b ov=%b want ff0030ff 0001 f",
               out_data, out_sat, out_v);
    end
    step();
  endtask

  task automatic test_valid_flags;
    func      = {2'b10, 2'b01, 2'b01, 2'b01};
    hist_data = {8'hFF, 8'h12, 8'h33, 8'h80};
    hist_v    = 4'b0010;
    cur_data  = {8'hF0, 8'h56, 8'h44, 8'h7A};
    cur_v     = 4'b1001;
    run_beat();
    checks++;
    if (out_data !== 32'hF000007A || out_v !== 4'b1001 ||
        out_sat !== 4'h0) begin
      errors++;
      $display("FAIL valid_flags got d=%h ov=%b s=%b want f000007a 1001 0",
               out_data, out_v, out_sat);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int         sent;
    int         rcv;
    bit         saw_block;
    logic [8:0] s;
    logic [7:0] e1;
    logic       exp_rdy;
    sent      = 0;
    rcv       = 0;
    saw_block = 1'b0;
    func      = {2'b00, 2'b00, 2'b10, 2'b11};
    hist_v    = 4'hF;
    cur_v     = 4'b0011;
    hist_data = {8'h00, 8'h00, 8'hF0, 8'hAA};
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      cur_data  = {16'h0000, 8'(sent * 8), 8'(sent + 1)};
      #1;
      exp_rdy = !((sent - rcv) == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_in_ready c=%0d got %b want %b",
                 c, in_ready, exp_rdy);
      end
      if (!in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        s  = 9'h0F0 + 9'(rcv * 8);
        e1 = s[8] ? 8'hFF : s[7:0];
        checks++;
        if (out_data !== {16'h0000, e1, 8'(rcv + 1)} ||
            out_sat !== {2'b00, s[8], 1'b0} || out_v !== 4'b0011) begin
          errors++;
          $display("FAIL b2b_data beat=%0d got d=%h s=%b want d=%h s=%b",
                   rcv, out_data, out_sat,
                   {16'h0000, e1, 8'(rcv + 1)}, {2'b00, s[8], 1'b0});
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv != 8 || sent != 8) begin
      errors++;
      $display("FAIL b2b_count got rcv=%0d sent=%0d want 8 8", rcv, sent);
    end
    checks++;
    if (!saw_block) begin
      errors++;
      $display("FAIL b2b_backpressure got never-blocked want in_ready low");
    end
    step();
    step();
  endtask

  task automatic test_clear;
    func      = 8'hFF;
    hist_v    = 4'hF;
    cur_v     = 4'hF;
    hist_data = '0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur_data  = 32'h01010101;
    step();
    cur_data  = 32'h02020202;
    step();
    cur_data  = 32'h03030303;
    clear     = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_pre got ov=%b rdy=%b want 1 0",
               out_valid, in_ready);
    end
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush got %b want 0", out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear_stale cyc=%0d got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid;
    func      = 8'hFF;
    hist_v    = 4'hF;
    cur_v     = 4'hF;
    cur_data  = 32'hA5A5A5A5;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 ||
        out_v !== '0 || out_sat !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got v=%b d=%h ov=%b s=%b want all 0",
               out_valid, out_data, out_v, out_sat);
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_ready got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale cyc=%0d got %b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    func      = '0;
    hist_data = '0;
    hist_v    = '0;
    cur_data  = '0;
    cur_v     = '0;
    test_reset();
    test_min_max();
    test_sum();
    test_valid_flags();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feat_extreme_alu.md
FEAT_EXTREME_ALU -- requirements
Module: feat_extreme_alu

Interface
REQ-001 Parameter DATA_W, default 8, lane data width in bits (legal 2..32).
REQ-002 Parameter NUM_CH, default 4, number of independent lanes (legal 1..16).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush of pipeline valids.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 func  input  2*NUM_CH  per-lane op: 00 min, 01 max, 10 saturating sum, 11 pass current.
REQ-009 hist_data  input  NUM_CH*DATA_W  per-lane stored feature value.
REQ-010 hist_v  input  NUM_CH  per-lane history-valid flag.
REQ-011 cur_data  input  NUM_CH*DATA_W  per-lane new sample.
REQ-012 cur_v  input  NUM_CH  per-lane sample-valid flag.
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_data  output  NUM_CH*DATA_W  per-lane result.
REQ-016 out_v  output  NUM_CH  per-lane result-valid flag.
REQ-017 out_sat  output  NUM_CH  per-lane saturation flag (op 10 only).

Function
REQ-018 Beat transfers on input when in_valid & in_ready; on output when out_valid & out_ready.
REQ-019 Two-stage pipeline (S1 compute register, S2 output register); accepted beat appears on out_valid exactly 2 cycles later when out_ready stays high.
REQ-020 in_ready = ~S1_valid | S1 advancing; S1 advances when ~S2_valid | out_ready; full throughput 1 beat/cycle under continuous out_ready.
REQ-021 With out_ready low, S2 and S1 hold unchanged; at most 2 beats in flight; no beat dropped or duplicated.
REQ-022 Lane cur_v=0: out_v=0, out_data=0, out_sat=0 for that lane regardless of func/hist.
REQ-023 Lane cur_v=1, hist_v=0: out_data=cur_data, out_v=1, out_sat=0, for every func.
REQ-024 Lane cur_v=1, hist_v=1: min -> unsigned smaller; max -> unsigned larger; ties return hist_data; hist_data value 0 is a real value, not an empty marker.
REQ-025 Sum op: DATA_W+1-bit add; carry out clamps out_data to all-ones and sets out_sat=1.
REQ-026 Pass op: out_data=cur_data irrespective of hist.
REQ-027 func, hist and cur sampled only at input transfer; later changes do not affect in-flight beats.
REQ-028 clear=1: S1/S2 valids cleared next edge, out_valid=0 next cycle, input beat in same cycle discarded, in_ready=0 during clear.
REQ-029 Lanes fully independent; one lane's result/saturation never alters another lane.

Reset
REQ-030 rst_n low asynchronously forces out_valid=0, out_data=0, out_v=0, out_sat=0, internal valids=0.
REQ-031 in_ready=1 from first cycle after rst_n deasserts; reset mid-stream discards all in-flight beats.

Structure
REQ-032 Shared package holds func encodings (FUNC_MIN/MAX/SUM/PASS) and default DATA_W/NUM_CH.
REQ-033 Per-lane arithmetic in sub-module feat_extreme_lane (combinational compare/add/clamp), generated NUM_CH times; pipeline/handshake in top.

Verification
REQ-034 Lane0 min, hist 0x05 v=1, cur 0x03 -> out 0x03 after 2 cycles; hist 0x00 v=1, cur 0x03 -> out 0x00.
REQ-035 Lane1 sum, hist 0xF0, cur 0x20 -> out 0xFF, out_sat=1; hist 0x10, cur 0x20 -> 0x30, out_sat=0.
REQ-036 Max, hist_v=0, cur 0x7A -> out 0x7A; cur_v=0 -> out_v=0, out_data=0.
REQ-037 Stream 8 beats, out_ready low cycles 3-6 -> in_ready low once 2 beats held, all 8 results in order, no loss.
REQ-038 clear with 2 beats in flight -> out_valid=0 next cycle, no stale beat later emitted.
REQ-039 rst_n pulse mid-stream -> outputs zero immediately, in_ready=1 after release.
